dvp_capture: RTL and testbench
==============================

DVP_CAPTURE -- requirements
Module: dvp_capture

Interface
REQ-001 Parameter SKIP_FRAMES, default 10: number of whole frames discarded after enable, for sensor settling.
REQ-002 Parameter FIFO_DEPTH, default 512: depth of the downstream write FIFO, in 16-bit words.
REQ-003 Parameter FULL_MARGIN, default 2: words of headroom below FIFO_DEPTH at which writes stop.
REQ-004 S_CLK  input  1  system clock; the DVP pixel bus is synchronous to it; one clock domain.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 capture_en  input  1  level; 1 = capture frames.
REQ-007 cam_vsync  input  1  frame sync, active high; high between frames.
REQ-008 cam_href  input  1  line-valid, active high.
REQ-009 cam_data  input  8  pixel byte; RGB565 high byte first.
REQ-010 fifo_wrusedw  input  9  fill level of the write FIFO.
REQ-011 ovf_clr  input  1  one-cycle pulse that clears overflow.
REQ-012 fifo_data  output  16  packed RGB565 pixel.
REQ-013 fifo_wrreq  output  1  write strobe, one cycle per pixel.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each captured frame.
REQ-015 capturing  output  1  high while in the CAPTURE state.
REQ-016 overflow  output  1  sticky flag: a pixel was dropped.

Function
REQ-017 cam_vsync shall be registered once; vs_rise = vsync & ~vsync_d; vs_fall = ~vsync & vsync_d.
REQ-018 The FSM shall have the states IDLE, SKIP, WAIT_VS and CAPTURE.
REQ-019 IDLE -> SKIP when capture_en=1; skip counter loaded to 0.
REQ-020 SKIP: the counter shall increment on each vs_rise.
REQ-021 SKIP -> WAIT_VS on the vs_rise that brings the count to SKIP_FRAMES.
REQ-022 SKIP_FRAMES=0 shall go IDLE -> WAIT_VS directly.
REQ-023 SKIP or WAIT_VS with capture_en=0 -> IDLE immediately.
REQ-024 WAIT_VS -> CAPTURE on vs_fall while capture_en=1.
REQ-025 On entry to CAPTURE the byte phase shall clear.
REQ-026 CAPTURE -> on vs_rise: frame_done=1 for one cycle, then to WAIT_VS if capture_en=1, else to IDLE.
REQ-027 Deasserting capture_en mid-frame shall not abort the frame; the frame completes.
REQ-028 Byte packing: while CAPTURE and cam_href=1, the byte phase shall toggle every cycle.
REQ-029 Phase 0: cam_data is latched as the high byte.
REQ-030 Phase 1: a pixel {high byte, cam_data} is formed.
REQ-031 Pixel latency: fifo_data and fifo_wrreq shall be registered and assert the cycle after the phase-1 byte.
REQ-032 cam_href=0 shall reset the byte phase to 0.
REQ-033 An odd trailing byte at line end shall be discarded silently.
REQ-034 Full rule: if fifo_wrusedw >= FIFO_DEPTH-FULL_MARGIN in the phase-1 cycle, fifo_wrreq shall stay 0, the pixel is dropped and overflow is set.
REQ-035 overflow shall clear only on ovf_clr or reset.
REQ-036 ovf_clr coincident with a new drop shall leave overflow=1 (set wins).
REQ-037 fifo_wrreq shall never assert outside CAPTURE.
REQ-038 fifo_data shall hold its last value when fifo_wrreq=0.
REQ-039 capturing shall equal (state==CAPTURE), registered.
REQ-040 vs_rise and cam_href=1 in the same cycle: the frame-end transition takes precedence and the byte is ignored.

Reset
REQ-041 While RST_N=0 the block shall hold: state IDLE; skip counter 0; byte phase 0; vsync_d 0.
REQ-042 While RST_N=0 all outputs shall be 0: fifo_data 16'h0000, fifo_wrreq, frame_done, capturing, overflow.
REQ-043 Reset asserted mid-frame shall take effect asynchronously and abort the frame without a frame_done.
REQ-044 After reset release the block shall restart the skip sequence from IDLE.

Configuration
REQ-045 Macro DVP_TEST_PATTERN_EN defined: fifo_data shall be a 16-bit counter instead of the camera pixel.
REQ-046 The counter shall clear on entry to CAPTURE and increment after each accepted write; all timing, href gating and the full rule are unchanged.
REQ-047 DVP_TEST_PATTERN_EN undefined: fifo_data shall be the packed camera pixel and no pattern logic shall be synthesised.

Verification
REQ-048 SKIP_FRAMES=2, capture_en=1, 3 frames of 4 lines x 8 bytes -> no wrreq in frames 1-2; frame 3 gives 16 writes, then one frame_done.
REQ-049 Bytes 8'hA5, 8'h3C under href -> fifo_data=16'hA53C with fifo_wrreq=1 exactly one cycle after 8'h3C.
REQ-050 Line of 7 bytes -> 3 writes; next line starts at phase 0.
REQ-051 fifo_wrusedw=510 during a pixel -> no write, overflow=1; ovf_clr pulse -> overflow=0.
REQ-052 capture_en dropped mid-frame -> all remaining pixels written, frame_done pulses, capturing=0, state IDLE; RST_N pulsed mid-line -> outputs 0 at once, no frame_done.
REQ-053 With DVP_TEST_PATTERN_EN defined, frame of 5 pixels -> fifo_data 0,1,2,3,4; next frame restarts at 0.

Source files
------------

// File: rtl/dvp_capture_if.sv
// Bundle of the DVP camera pins, capture control and write-FIFO signals.
// The master side is the environment (sensor, FIFO, host); the slave side is dvp_capture.
interface dvp_capture_if;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [8:0]  fifo_wrusedw;
  logic        ovf_clr;
  logic [15:0] fifo_data;
  logic        fifo_wrreq;
  logic        frame_done;
  logic        capturing;
  logic        overflow;

  modport master (
    output capture_en, cam_vsync, cam_href, cam_data, fifo_wrusedw, ovf_clr,
    input  fifo_data, fifo_wrreq, frame_done, capturing, overflow
  );

  modport slave (
    input  capture_en, cam_vsync, cam_href, cam_data, fifo_wrusedw, ovf_clr,
    output fifo_data, fifo_wrreq, frame_done, capturing, overflow
  );
endinterface

// File: rtl/dvp_capture.sv
// DVP camera capture: skips settling frames, packs RGB565 byte pairs and writes them to a FIFO.
// Define DVP_TEST_PATTERN_EN to replace the camera pixel with an incrementing 16-bit counter.
module dvp_capture #(
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned FULL_MARGIN = 2
) (
  input logic          S_CLK,
  input logic          RST_N,
  dvp_capture_if.slave bus
);

  localparam int unsigned SKIP_W     = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int unsigned FULL_LEVEL = FIFO_DEPTH - FULL_MARGIN;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    WAIT_VS,
    CAPTURE
  } state_e;

  state_e              state_q;
  logic [SKIP_W-1:0]   skip_cnt_q;
  logic                vsync_q;
  logic                phase_q;
  logic [15:0]         data_q;
  logic                wrreq_q;
  logic                done_q;
  logic                capturing_q;
  logic                ovf_q;
`ifdef DVP_TEST_PATTERN_EN
  logic [15:0]         pat_q;
`else
  logic [7:0]          hi_q;
`endif

  logic vs_rise;
  logic vs_fall;
  logic full;

  assign vs_rise = bus.cam_vsync & ~vsync_q;
  assign vs_fall = ~bus.cam_vsync & vsync_q;
  assign full    = 32'(bus.fifo_wrusedw) >= FULL_LEVEL;

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      skip_cnt_q  <= '0;
      vsync_q     <= 1'b0;
      phase_q     <= 1'b0;
      data_q      <= '0;
      wrreq_q     <= 1'b0;
      done_q      <= 1'b0;
      capturing_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef DVP_TEST_PATTERN_EN
      pat_q       <= '0;
`else
      hi_q        <= '0;
`endif
    end else begin
      vsync_q <= bus.cam_vsync;
      wrreq_q <= 1'b0;
      done_q  <= 1'b0;
      // A drop later in this block overrides the clear, so a coincident drop keeps the flag set.
      if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.capture_en) begin
            skip_cnt_q <= '0;
            if (SKIP_FRAMES == 0) begin
              state_q <= WAIT_VS;
            end else begin
              state_q <= SKIP;
            end
          end
        end

        SKIP: begin
          if (!bus.capture_en) begin
            state_q <= IDLE;
          end else if (vs_rise) begin
            skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
            if (skip_cnt_q == SKIP_LAST) begin
              state_q <= WAIT_VS;
            end
          end
        end

        WAIT_VS: begin
          if (!bus.capture_en) begin
            state_q <= IDLE;
          end else if (vs_fall) begin
            state_q     <= CAPTURE;
            capturing_q <= 1'b1;
            phase_q     <= 1'b0;
`ifdef DVP_TEST_PATTERN_EN
            pat_q       <= '0;
`endif
          end
        end

        CAPTURE: begin
          // Frame end outranks any byte presented in the same cycle; capture_en is only
          // consulted here so a frame in progress always completes.
          if (vs_rise) begin
            done_q      <= 1'b1;
            phase_q     <= 1'b0;
            capturing_q <= 1'b0;
            state_q     <= bus.capture_en ? WAIT_VS : IDLE;
          end else if (!bus.cam_href) begin
            phase_q <= 1'b0;
          end else if (!phase_q) begin
            phase_q <= 1'b1;
`ifndef DVP_TEST_PATTERN_EN
            hi_q    <= bus.cam_data;
`endif
          end else begin
            phase_q <= 1'b0;
            if (full) begin
              ovf_q <= 1'b1;
            end else begin
              wrreq_q <= 1'b1;
`ifdef DVP_TEST_PATTERN_EN
              data_q  <= pat_q;
              pat_q   <= pat_q + 16'd1;
`else
              data_q  <= {hi_q, bus.cam_data};
`endif
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          capturing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_data  = data_q;
  assign bus.fifo_wrreq = wrreq_q;
  assign bus.frame_done = done_q;
  assign bus.capturing  = capturing_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_dvp_capture.sv
// Randomized self-checking bench for dvp_capture; expected pixels come from a frame/line level model.
module tb_dvp_capture;

  localparam int SKIP       = 2;
  localparam int FULL_LEVEL = 512 - 2;

  logic S_CLK = 1'b0;
  logic RST_N;

  always #5 S_CLK = ~S_CLK;

  dvp_capture_if bus ();

  dvp_capture #(
    .SKIP_FRAMES (SKIP),
    .FIFO_DEPTH  (512),
    .FULL_MARGIN (2)
  ) dut (
    .S_CLK (S_CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observed traffic, only ever appended by the monitor.
  logic [15:0] got[$];
  int          done_cnt = 0;
  int          stray_wr = 0;

  always @(negedge S_CLK) begin
    if (bus.fifo_wrreq) got.push_back(bus.fifo_data);
    if (bus.frame_done) done_cnt++;
    if (bus.fifo_wrreq && !bus.capturing) stray_wr++;
  end

  // Reference model state and current frame stimulus.
  logic [15:0] exp_q[$];
  bit          ovf_exp;
  logic [15:0] pat_next;
  int          ln[$];
  logic [7:0]  by[$];
  logic [8:0]  uw[$];

  function automatic logic [15:0] exp_pixel(input logic [7:0] hi, input logic [7:0] lo);
`ifdef DVP_TEST_PATTERN_EN
    exp_pixel = pat_next;
    pat_next  = pat_next + 16'd1;
`else
    exp_pixel = {hi, lo};
`endif
  endfunction

  function automatic int first_diff(input int base);
    for (int i = 0; (base + i) < got.size() && i < exp_q.size(); i++)
      if (got[base + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic build_frame(input int nlines, input int minlen, input int maxlen);
    ln.delete(); by.delete(); uw.delete();
    for (int l = 0; l < nlines; l++) begin
      int n;
      n = int'($urandom_range(maxlen, minlen));
      ln.push_back(n);
      for (int b = 0; b < n; b++) begin
        by.push_back(8'($urandom));
        uw.push_back(9'($urandom_range(FULL_LEVEL - 1, 0)));
      end
    end
  endtask

  task automatic frame_open();
    bus.cam_vsync = 1'b1;
    repeat (3) step();
    bus.cam_vsync = 1'b0;
    pat_next      = 16'd0;
    repeat (2) step();
  endtask

  task automatic frame_close();
    bus.cam_vsync = 1'b1;
    repeat (3) step();
  endtask

  task automatic drive_lines(input int from, input int to);
    int p = 0;
    for (int l = 0; l < from; l++) p += ln[l];
    for (int l = from; l < to; l++) begin
      for (int b = 0; b < ln[l]; b++) begin
        bus.cam_href     = 1'b1;
        bus.cam_data     = by[p + b];
        bus.fifo_wrusedw = uw[p + b];
        step();
      end
      bus.cam_href     = 1'b0;
      bus.fifo_wrusedw = '0;
      bus.cam_data     = 8'($urandom);
      repeat (3) step();
      p += ln[l];
    end
  endtask

  // Each line yields floor(len/2) pixels; a pair whose second byte sees a full FIFO is dropped.
  task automatic model_lines(input int from, input int to, input bit captured);
    int p = 0;
    if (!captured) return;
    for (int l = 0; l < from; l++) p += ln[l];
    for (int l = from; l < to; l++) begin
      for (int k = 0; k < ln[l] / 2; k++) begin
        int i;
        i = p + 2 * k;
        if (int'(uw[i + 1]) >= FULL_LEVEL) ovf_exp = 1'b1;
        else exp_q.push_back(exp_pixel(by[i], by[i + 1]));
      end
      p += ln[l];
    end
  endtask

  task automatic send_frame(input bit captured);
    frame_open();
    drive_lines(0, ln.size());
    frame_close();
    model_lines(0, ln.size(), captured);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.fifo_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", bus.fifo_data); else n_pass++;
    n_checks++; if (bus.fifo_wrreq !== 1'b0) $display("FAIL reset_wrreq: got %b want 0", bus.fifo_wrreq); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.capturing !== 1'b0) $display("FAIL reset_capturing: got %b want 0", bus.capturing); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else n_pass++;
    RST_N = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_skip_frames();
    int base, db, d;
    base = got.size(); db = done_cnt; exp_q.delete();
    bus.capture_en = 1'b1;
    step();
    for (int f = 0; f < SKIP; f++) begin
      build_frame(4, 8, 8);
      send_frame(1'b0);
    end
    n_checks++; if (got.size() - base !== 0) $display("FAIL skip_no_writes: got %0d writes want 0", got.size() - base); else n_pass++;
    n_checks++; if (done_cnt - db !== 0) $display("FAIL skip_no_done: got %0d want 0", done_cnt - db); else n_pass++;
    build_frame(4, 8, 8);
    frame_open();
    n_checks++; if (bus.capturing !== 1'b1) $display("FAIL skip_capturing: got %b want 1", bus.capturing); else n_pass++;
    drive_lines(0, 4);
    frame_close();
    model_lines(0, 4, 1'b1);
    n_checks++; if (got.size() - base !== 16) $display("FAIL frame3_count: got %0d want 16", got.size() - base); else n_pass++;
    d = first_diff(base);
    n_checks++; if (d >= 0) $display("FAIL frame3_data: idx %0d got %h want %h", d, got[base + d], exp_q[d]); else n_pass++;
    n_checks++; if (done_cnt - db !== 1) $display("FAIL frame3_done: got %0d want 1", done_cnt - db); else n_pass++;
    n_checks++; if (bus.capturing !== 1'b0) $display("FAIL frame3_idle: capturing %b want 0", bus.capturing); else n_pass++;
  endtask

  task automatic test_pack_latency();
    logic [15:0] want;
    frame_open();
    bus.cam_href = 1'b1; bus.cam_data = 8'hA5; bus.fifo_wrusedw = '0;
    step();
    n_checks++; if (bus.fifo_wrreq !== 1'b0) $display("FAIL lat_early: wrreq %b want 0", bus.fifo_wrreq); else n_pass++;
    bus.cam_data = 8'h3C;
    want = exp_pixel(8'hA5, 8'h3C);
    step();
    n_checks++; if (bus.fifo_wrreq !== 1'b1) $display("FAIL lat_wrreq: wrreq %b want 1", bus.fifo_wrreq); else n_pass++;
    n_checks++; if (bus.fifo_data !== want) $display("FAIL lat_data: got %h want %h", bus.fifo_data, want); else n_pass++;
    bus.cam_href = 1'b0; bus.cam_data = 8'h77;
    step();
    n_checks++; if (bus.fifo_wrreq !== 1'b0) $display("FAIL lat_single: wrreq %b want 0", bus.fifo_wrreq); else n_pass++;
    n_checks++; if (bus.fifo_data !== want) $display("FAIL lat_hold: got %h want %h", bus.fifo_data, want); else n_pass++;
  endtask

  task automatic test_odd_line();
    int base, db, d;
    base = got.size(); db = done_cnt; exp_q.delete();
    ln = '{7, 4}; by.delete(); uw.delete();
    for (int i = 0; i < 11; i++) begin
      by.push_back(8'($urandom));
      uw.push_back(9'($urandom_range(FULL_LEVEL - 1, 0)));
    end
    model_lines(0, 2, 1'b1);
    drive_lines(0, 1);
    n_checks++; if (got.size() - base !== 3) $display("FAIL odd_count: got %0d want 3", got.size() - base); else n_pass++;
    drive_lines(1, 2);
    frame_close();
    n_checks++; if (got.size() - base !== exp_q.size()) $display("FAIL odd_total: got %0d want %0d", got.size() - base, exp_q.size()); else n_pass++;
    d = first_diff(base);
    n_checks++; if (d >= 0) $display("FAIL odd_data: idx %0d got %h want %h", d, got[base + d], exp_q[d]); else n_pass++;
    n_checks++; if (done_cnt - db !== 1) $display("FAIL odd_done: got %0d want 1", done_cnt - db); else n_pass++;
  endtask

  task automatic test_random_frames();
    int base, db, d;
    base = got.size(); db = done_cnt; exp_q.delete();
    for (int f = 0; f < 4; f++) begin
      build_frame(int'($urandom_range(5, 1)), 0, 20);
      send_frame(1'b1);
    end
    n_checks++; if (got.size() - base !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got.size() - base, exp_q.size()); else n_pass++;
    d = first_diff(base);
    n_checks++; if (d >= 0) $display("FAIL rand_data: idx %0d got %h want %h", d, got[base + d], exp_q[d]); else n_pass++;
    n_checks++; if (done_cnt - db !== 4) $display("FAIL rand_done: got %0d want 4", done_cnt - db); else n_pass++;
    n_checks++; if (bus.overflow !== ovf_exp) $display("FAIL rand_overflow: got %b want %b", bus.overflow, ovf_exp); else n_pass++;
  endtask

  task automatic test_overflow();
    int base, d;
    base = got.size(); exp_q.delete();
    build_frame(2, 8, 8);
    uw[3]  = 9'd510;
    uw[10] = 9'd511;
    uw[13] = 9'd509;
    send_frame(1'b1);
    n_checks++; if (got.size() - base !== exp_q.size()) $display("FAIL ovf_count: got %0d want %0d", got.size() - base, exp_q.size()); else n_pass++;
    d = first_diff(base);
    n_checks++; if (d >= 0) $display("FAIL ovf_data: idx %0d got %h want %h", d, got[base + d], exp_q[d]); else n_pass++;
    n_checks++; if (bus.overflow !== ovf_exp) $display("FAIL ovf_set: got %b want %b", bus.overflow, ovf_exp); else n_pass++;
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    ovf_exp = 1'b0;
    n_checks++; if (bus.overflow !== ovf_exp) $display("FAIL ovf_clear: got %b want %b", bus.overflow, ovf_exp); else n_pass++;
    base = got.size();
    frame_open();
    bus.cam_href = 1'b1; bus.cam_data = 8'h11; bus.fifo_wrusedw = '0;
    step();
    bus.cam_data = 8'h22; bus.fifo_wrusedw = 9'd511; bus.ovf_clr = 1'b1;
    step();
    ovf_exp = 1'b1;
    n_checks++; if (bus.overflow !== ovf_exp) $display("FAIL ovf_set_wins: got %b want %b", bus.overflow, ovf_exp); else n_pass++;
    bus.ovf_clr = 1'b0; bus.cam_href = 1'b0; bus.fifo_wrusedw = '0;
    step();
    frame_close();
    n_checks++; if (got.size() - base !== 0) $display("FAIL ovf_full_write: got %0d writes want 0", got.size() - base); else n_pass++;
  endtask

  task automatic test_precedence();
    int base, db;
    base = got.size(); db = done_cnt;
    frame_open();
    bus.cam_href = 1'b1; bus.cam_data = 8'($urandom);
    step();
    bus.cam_vsync = 1'b1; bus.cam_data = 8'($urandom);
    step();
    n_checks++; if (bus.frame_done !== 1'b1) $display("FAIL prec_done: got %b want 1", bus.frame_done); else n_pass++;
    bus.cam_href = 1'b0;
    repeat (3) step();
    n_checks++; if (got.size() - base !== 0) $display("FAIL prec_nowrite: got %0d writes want 0", got.size() - base); else n_pass++;
    n_checks++; if (done_cnt - db !== 1) $display("FAIL prec_done_once: got %0d want 1", done_cnt - db); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int base, db, d;
    base = got.size(); db = done_cnt; exp_q.delete();
    build_frame(3, 6, 6);
    frame_open();
    drive_lines(0, 1);
    bus.capture_en = 1'b0;
    drive_lines(1, 3);
    frame_close();
    model_lines(0, 3, 1'b1);
    n_checks++; if (got.size() - base !== 9) $display("FAIL endrop_count: got %0d want 9", got.size() - base); else n_pass++;
    d = first_diff(base);
    n_checks++; if (d >= 0) $display("FAIL endrop_data: idx %0d got %h want %h", d, got[base + d], exp_q[d]); else n_pass++;
    n_checks++; if (done_cnt - db !== 1) $display("FAIL endrop_done: got %0d want 1", done_cnt - db); else n_pass++;
    n_checks++; if (bus.capturing !== 1'b0) $display("FAIL endrop_capturing: got %b want 0", bus.capturing); else n_pass++;
    base = got.size();
    build_frame(2, 4, 4);
    frame_open();
    n_checks++; if (bus.capturing !== 1'b0) $display("FAIL endrop_idle: capturing %b want 0", bus.capturing); else n_pass++;
    drive_lines(0, 2);
    frame_close();
    n_checks++; if (got.size() - base !== 0) $display("FAIL endrop_idle_writes: got %0d want 0", got.size() - base); else n_pass++;
  endtask

  task automatic test_reset_midline();
    int base, db, d;
    bus.capture_en = 1'b1;
    step();
    for (int f = 0; f < SKIP; f++) begin
      build_frame(2, 4, 4);
      send_frame(1'b0);
    end
    frame_open();
    bus.cam_href = 1'b1; bus.cam_data = 8'($urandom);
    step();
    bus.cam_data = 8'($urandom);
    step();
    n_checks++; if (bus.fifo_wrreq !== 1'b1) $display("FAIL rst_setup: wrreq %b want 1", bus.fifo_wrreq); else n_pass++;
    db = done_cnt;
    #2 RST_N = 1'b0;
    #1;
    n_checks++; if (bus.fifo_wrreq !== 1'b0) $display("FAIL rst_async_wrreq: got %b want 0", bus.fifo_wrreq); else n_pass++;
    n_checks++; if (bus.fifo_data !== 16'h0000) $display("FAIL rst_async_data: got %h want 0000", bus.fifo_data); else n_pass++;
    n_checks++; if (bus.capturing !== 1'b0) $display("FAIL rst_async_capturing: got %b want 0", bus.capturing); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL rst_async_overflow: got %b want 0", bus.overflow); else n_pass++;
    bus.cam_href = 1'b0; bus.cam_vsync = 1'b1;
    repeat (2) step();
    n_checks++; if (done_cnt - db !== 0) $display("FAIL rst_no_done: got %0d want 0", done_cnt - db); else n_pass++;
    RST_N = 1'b1;
    ovf_exp = 1'b0;
    base = got.size(); exp_q.delete();
    for (int f = 0; f < SKIP; f++) begin
      build_frame(2, 4, 4);
      send_frame(1'b0);
    end
    n_checks++; if (got.size() - base !== 0) $display("FAIL rst_reskip: got %0d writes want 0", got.size() - base); else n_pass++;
    build_frame(2, 6, 6);
    send_frame(1'b1);
    n_checks++; if (got.size() - base !== 6) $display("FAIL rst_resume_count: got %0d want 6", got.size() - base); else n_pass++;
    d = first_diff(base);
    n_checks++; if (d >= 0) $display("FAIL rst_resume_data: idx %0d got %h want %h", d, got[base + d], exp_q[d]); else n_pass++;
    n_checks++; if (done_cnt - db !== 1) $display("FAIL rst_resume_done: got %0d want 1", done_cnt - db); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N            = 1'b0;
    bus.capture_en   = 1'b0;
    bus.cam_vsync    = 1'b1;
    bus.cam_href     = 1'b0;
    bus.cam_data     = '0;
    bus.fifo_wrusedw = '0;
    bus.ovf_clr      = 1'b0;
    ovf_exp          = 1'b0;
    pat_next         = 16'd0;

    test_reset();
    test_skip_frames();
    test_pack_latency();
    test_odd_line();
    test_random_frames();
    test_overflow();
    test_precedence();
    test_enable_drop();
    test_reset_midline();

    n_checks++; if (stray_wr !== 0) $display("FAIL wrreq_outside_capture: got %0d want 0", stray_wr); else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
